// File: rtl/ifetch_byte_assembler.sv
// ifetch_byte_assembler
//   Fetch stage that sits right after the PC. It takes one byte address and
//   reads four consecutive bytes from a byte-wide synchronous instruction
//   memory with one cycle of read latency. The bytes are assembled
//   little-endian into a 32-bit instruction and handed to decode over
//   valid/ready. A request whose address is not word-aligned never touches
//   memory. Instead it is answered with NOP_INSTR and instr_fault set.
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   pc_in, req_valid        fetch request (byte address)
//   req_ready               unit is idle and can take a request this cycle
//   flush                   drop the in-flight fetch or the held instruction
//   mem_en, mem_addr        memory read request (byte address)
//   mem_rdata               memory data, one cycle after mem_en
//   instr_out, instr_pc     assembled instruction and its fetch address
//   instr_fault             misaligned request
//   instr_valid, instr_ready  handshake toward decode

// One captured byte lane. It is cleared on flush so that a discarded fetch
// leaves nothing behind.
module ifetch_byte_lane #(
    parameter int VEC_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             we,
    input  logic [VEC_W-1:0] d,
    output logic [VEC_W-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    q <= '0;
        else if (clr) q <= '0;
        else if (we)  q <= d;
    end
endmodule

module ifetch_byte_assembler #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              flush,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_fault,
    output logic              instr_valid,
    input  logic              instr_ready
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

    state_t                                 state_q, state_d;
    logic [ADDR_W-1:0]                      base;
    logic [1:0]                             issue_cnt;
    logic [1:0]                             cap_cnt;
    logic                                   rd_vld;     // mem_rdata carries an issued byte this cycle
    logic                                   issue_vld;
    logic                                   accept;
    logic                                   aligned;
    logic                                   cap_en;
    logic                                   cap_last;
    logic [NUM_LANES-2:0]                   lane_we;
    logic [NUM_LANES-2:0][VEC_W-1:0]        lane_q;

    // reset is included so that req_ready only rises once reset is released.
    assign req_ready = (state_q == IDLE) && !flush && !reset;
    assign accept    = req_valid && req_ready;
    assign aligned   = (pc_in[1:0] == 2'b00);

    assign mem_en    = (state_q == ISSUE);
    assign mem_addr  = base + ADDR_W'(issue_cnt);

    // A read issued in a flush cycle is never marked valid. A byte arriving
    // during a flush cycle is not captured, so late data cannot leak into
    // the next fetch.
    assign issue_vld = mem_en && !flush;
    assign cap_en    = rd_vld && !flush;
    assign cap_last  = cap_en && (cap_cnt == 2'd3);

    // Bytes 0..2 are parked in lanes. Byte 3 is taken straight from
    // mem_rdata on the final edge, so instr_out only ever changes to a
    // complete word.
    for (genvar i = 0; i < NUM_LANES - 1; i++) begin : g_lane
        assign lane_we[i] = cap_en && (cap_cnt == 2'(i));
        ifetch_byte_lane #(.VEC_W(VEC_W)) u_lane (
            .clk   (clk),
            .reset (reset),
            .clr   (flush),
            .we    (lane_we[i]),
            .d     (mem_rdata),
            .q     (lane_q[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = aligned ? ISSUE : HOLD;
            ISSUE:   if (issue_cnt == 2'd3) state_d = DRAIN;
            DRAIN:   if (cap_last) state_d = HOLD;
            HOLD:    if (instr_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Flush wins over everything, including instr_ready in HOLD.
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base        <= '0;
            issue_cnt   <= '0;
            cap_cnt     <= '0;
            rd_vld      <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_fault <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            rd_vld <= issue_vld;
            if (flush) begin
                issue_cnt   <= '0;
                cap_cnt     <= '0;
                instr_valid <= 1'b0;
            end else begin
                if (accept) begin
                    base      <= pc_in;
                    issue_cnt <= '0;
                    cap_cnt   <= '0;
                    if (!aligned) begin
                        instr_out   <= NOP_INSTR;
                        instr_pc    <= pc_in;
                        instr_fault <= 1'b1;
                        instr_valid <= 1'b1;
                    end
                end
                if (issue_vld) issue_cnt <= issue_cnt + 2'd1;
                if (cap_en)    cap_cnt   <= cap_cnt + 2'd1;
                if (cap_last) begin
                    instr_out   <= {mem_rdata, lane_q};
                    instr_pc    <= base;
                    instr_fault <= 1'b0;
                    instr_valid <= 1'b1;
                end
                if (state_q == HOLD && instr_ready) instr_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/ifetch_byte_assembler.md
Name: ifetch_byte_assembler

Overview:
Instruction fetch stage directly downstream of the program counter. It accepts a 10-bit byte address, reads four consecutive bytes from the byte-wide synchronous instruction memory (1024 B), and assembles them little-endian into one 32-bit instruction. It presents the instruction to decode over a valid/ready handshake. A flush input drops any in-flight fetch when a branch or jump redirects the PC.

Parameters:
ADDR_W, 10, byte address width; memory size is 2^ADDR_W bytes
NOP_INSTR, 32'h00000013, word driven on instr_out for a faulted (misaligned) fetch

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
pc_in  input  ADDR_W  byte address of instruction to fetch
req_valid  input  1  pc_in is valid this cycle
req_ready  output  1  unit can accept a request this cycle
flush  input  1  abort in-flight fetch / discard held instruction
mem_en  output  1  memory read enable
mem_addr  output  ADDR_W  memory byte address
mem_rdata  input  8  memory read data, valid one cycle after mem_en/mem_addr
instr_out  output  32  assembled instruction, byte0 in [7:0] ... byte3 in [31:24]
instr_pc  output  ADDR_W  address the instruction was fetched from
instr_fault  output  1  misaligned request (pc_in[1:0] != 0)
instr_valid  output  1  instr_out/instr_pc/instr_fault valid
instr_ready  input  1  decode accepts instruction this cycle

Behaviour:
- Reset (async): state=IDLE; req_ready=1 once reset deasserts; mem_en=0, mem_addr=0, instr_out=0, instr_pc=0, instr_fault=0, instr_valid=0; byte counters=0.
- States: IDLE, ISSUE, DRAIN, HOLD.
- IDLE: req_ready=1 (0 if flush=1). Accept on req_valid&&req_ready: latch base=pc_in. Aligned -> ISSUE, issue_cnt=0. Misaligned -> HOLD with instr_out=NOP_INSTR, instr_fault=1, instr_pc=pc_in, no memory access.
- ISSUE: mem_en=1, mem_addr=(base+issue_cnt) mod 2^ADDR_W. issue_cnt increments each cycle. After issuing offset 3 -> DRAIN.
- Data capture: mem_rdata is written into byte lane cap_cnt on the edge following each cycle in which issued data is valid. This starts one cycle after the first issue and continues through ISSUE and DRAIN.
- DRAIN: mem_en=0. When byte 3 is captured -> HOLD with instr_valid=1, instr_fault=0.
- Latency: instr_valid rises after the 5th rising edge following the accepting edge. That is 4 issue cycles plus 1 memory latency cycle.
- HOLD: instr_valid=1; outputs stable until instr_ready=1. On handshake -> IDLE; instr_valid=0 the next cycle. req_ready=0 in ISSUE/DRAIN/HOLD; no back-to-back overlap.
- Flush: in any state, next edge -> IDLE, instr_valid=0, mem_en=0. Captured bytes are discarded, and a late mem_rdata from an already-issued read is ignored. Flush beats instr_ready in HOLD, so the instruction is not considered consumed. Flush in IDLE blocks acceptance that cycle.
- Address wrap: base=1022 reads bytes 1022,1023,0,1. This only occurs for misaligned bases, which fault, so aligned fetches never wrap mid-word. Address arithmetic is still mod 2^ADDR_W.
- Reset mid-operation: outputs return to reset values asynchronously. No partial instruction is ever presented.
- instr_out holds its last value when instr_valid=0. No X may appear on outputs after reset.

Test Plan:
- Reset then req pc_in=0x000, mem bytes [0..3]=13,05,00,00 -> mem_addr 0,1,2,3 on consecutive cycles; instr_valid after 5 edges with instr_out=32'h00000513, instr_pc=0, instr_fault=0.
- Decode backpressure: instr_ready=0 for 3 cycles -> instr_out/instr_valid stable; ready=1 -> next cycle instr_valid=0, req_ready=1.
- Misaligned pc_in=0x006 -> no mem_en; next cycle instr_valid=1, instr_fault=1, instr_out=32'h00000013, instr_pc=0x006.
- Flush during ISSUE after 2 bytes issued -> next cycle IDLE, instr_valid never asserts; new request to 0x3FC fetches bytes 0x3FC..0x3FF correctly, with no stale bytes.
- Flush and instr_ready both high in HOLD -> IDLE, with no double consumption counted by the scoreboard; simultaneous flush+req_valid in IDLE -> request not accepted.
- Async reset asserted mid-DRAIN (between edges) -> mem_en, instr_valid drop immediately; after release the fetch of 0x004 returns the correct word.
